// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
//
// Walks a 4-input combinational function through all 16 input vectors. Each
// vector is held for SETTLE cycles. f_in is sampled on the last edge of each
// window and collected into a truth table. The table is then compared
// against an expected table that was captured when the sweep started.
//
// Parameters
//   SETTLE     cycles each vector is held before it is sampled (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      sweep request, only looked at while idle
//   abort      sweep cancel, only acted on while running
//   exp_tt     expected truth table, captured when start is accepted
//   f_in       output of the function under test
//   a,b,c,d    vector driven to the function, {a,b,c,d} = vec, a is the MSB
//   busy       high from start acceptance until the done cycle ends
//   done       one-cycle completion pulse
//   tt         captured truth table, bit i = f_in for vector i
//   ones       popcount of tt (valid with done, held afterwards)
//   err        tt differs from the captured expected table
//   first_err  lowest mismatching vector index, 0 when err is 0
// ---------------------------------------------------------------------------
module tt_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_tt,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  ones,
  output logic        err,
  output logic [3:0]  first_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  vec;
  logic [3:0]  cnt;
  logic [15:0] exp_q;
  logic [15:0] tt_upd;
  logic [15:0] diff_upd;
  logic        win_end;
  logic        last_smp;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Scanning from the top down leaves the lowest set index in idx;
  // an all-zero vector yields 0.
  function automatic logic [3:0] lowest_set16(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Table as it will look after the current sample is written. The final
  // sample feeds the summary results directly so that they are already
  // registered during the done cycle.
  always_comb begin
    tt_upd      = tt;
    tt_upd[vec] = f_in;
  end

  assign diff_upd = tt_upd ^ exp_q;

  // Abort wins over a sample that falls on the same edge.
  assign win_end  = (state == RUN) && !abort && (cnt == CNT_LAST);
  assign last_smp = win_end && (vec == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_smp) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      tt        <= '0;
      exp_q     <= '0;
      ones      <= '0;
      err       <= 1'b0;
      first_err <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            tt        <= '0;
            exp_q     <= exp_tt;
            ones      <= '0;
            err       <= 1'b0;
            first_err <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial table and summary results are left as they are.
            vec <= '0;
            cnt <= '0;
          end else if (win_end) begin
            tt  <= tt_upd;
            cnt <= '0;
            // vec wraps to 0 after vector 15, so the function sees 0000 in DONE.
            vec <= vec + 4'd1;
            if (last_smp) begin
              ones      <= popcount16(tt_upd);
              err       <= |diff_upd;
              first_err <= lowest_set16(diff_upd);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign {a, b, c, d} = vec;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//
// Two instances run side by side: SETTLE=2 and SETTLE=1. They share the
// control inputs. 'sel' picks which instance's outputs are observed. The
// function under test is a lookup table fn_tt indexed by each DUT's own
// {a,b,c,d}. Expected values come from the sweep rules: vector k/S is driven
// k cycles after acceptance, the table equals fn_tt (masked for an abort),
// and the popcount, mismatch and first-mismatch values come from plain loops.
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] exp_tt;
  logic [15:0] fn_tt;
  logic        sel;

  logic        a0, b0, c0, d0, busy0, done0, err0, f0;
  logic [15:0] tt0;
  logic [4:0]  ones0;
  logic [3:0]  fe0;
  logic        a1, b1, c1, d1, busy1, done1, err1, f1;
  logic [15:0] tt1;
  logic [4:0]  ones1;
  logic [3:0]  fe1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign f0 = fn_tt[{a0, b0, c0, d0}];
  assign f1 = fn_tt[{a1, b1, c1, d1}];

  tt_sweep_ctrl #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
    .f_in(f0), .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .tt(tt0), .ones(ones0), .err(err0), .first_err(fe0)
  );

  tt_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
    .f_in(f1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .tt(tt1), .ones(ones1), .err(err1), .first_err(fe1)
  );

  logic [3:0]  vec_s;
  logic        busy_s, done_s, err_s;
  logic [15:0] tt_s;
  logic [4:0]  ones_s;
  logic [3:0]  fe_s;

  assign vec_s  = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign err_s  = sel ? err1  : err0;
  assign tt_s   = sel ? tt1   : tt0;
  assign ones_s = sel ? ones1 : ones0;
  assign fe_s   = sel ? fe1   : fe0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, expv, $time, sel);
    end
  endtask

  function automatic int m_ones(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int m_first(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy0 || busy1) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  // One sweep on the selected instance. Starts from IDLE. j = 0 means no
  // abort; otherwise abort is raised j cycles after acceptance and is seen
  // on the following edge.
  task automatic run_sweep(input logic [15:0] fn, input logic [15:0] ex,
                           input bit hold, input int j);
    int          S;
    int          nsmp;
    logic [15:0] exp_tab;
    bit          aborted;
    S       = sel ? 1 : 2;
    fn_tt   = fn;
    exp_tt  = ex;
    start   = 1'b1;
    abort   = ($urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    abort   = 1'b0;
    if (!hold) start = 1'b0;
    exp_tt  = 16'($urandom);
    aborted = 1'b0;
    chk("acc_busy", 32'(busy_s), 32'd1);
    chk("acc_vec",  32'(vec_s),  32'd0);
    chk("acc_tt",   32'(tt_s),   32'd0);
    chk("acc_ones", 32'(ones_s), 32'd0);
    chk("acc_err",  32'(err_s),  32'd0);
    for (int k = 1; k <= 16 * S + 1; k++) begin
      @(posedge clk); #1;
      if (j > 0 && j < 16 * S && k == j + 1) begin
        abort   = 1'b0;
        aborted = 1'b1;
        nsmp    = j / S;
        exp_tab = fn & 16'((32'd1 << nsmp) - 1);
        chk("abt_busy", 32'(busy_s), 32'd0);
        chk("abt_done", 32'(done_s), 32'd0);
        chk("abt_vec",  32'(vec_s),  32'd0);
        chk("abt_tt",   32'(tt_s),   32'(exp_tab));
        chk("abt_ones", 32'(ones_s), 32'd0);
        chk("abt_err",  32'(err_s),  32'd0);
        chk("abt_fe",   32'(fe_s),   32'd0);
        break;
      end
      if (k < 16 * S) begin
        chk("run_vec",  32'(vec_s),  32'(k / S));
        chk("run_busy", 32'(busy_s), 32'd1);
        chk("run_done", 32'(done_s), 32'd0);
      end else if (k == 16 * S) begin
        chk("dn_done", 32'(done_s), 32'd1);
        chk("dn_busy", 32'(busy_s), 32'd1);
        chk("dn_vec",  32'(vec_s),  32'd0);
        chk("dn_tt",   32'(tt_s),   32'(fn));
        chk("dn_ones", 32'(ones_s), 32'(m_ones(fn)));
        chk("dn_err",  32'(err_s),  32'(fn != ex));
        chk("dn_fe",   32'(fe_s),   32'(m_first(fn ^ ex)));
      end else begin
        abort = 1'b0;
        chk("post_done", 32'(done_s), 32'd0);
        chk("post_busy", 32'(busy_s), 32'd0);
        chk("post_ones", 32'(ones_s), 32'(m_ones(fn)));
        chk("post_err",  32'(err_s),  32'(fn != ex));
        chk("post_fe",   32'(fe_s),   32'(m_first(fn ^ ex)));
      end
      if (k == j) begin
        abort = 1'b1;
        start = 1'b0;
      end
    end
    if (!aborted && start) begin
      @(posedge clk); #1;
      chk("restart_busy", 32'(busy_s), 32'd1);
      chk("restart_tt",   32'(tt_s),   32'd0);
      chk("restart_ones", 32'(ones_s), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fn;
    logic [15:0] ex;
    int          S;
    int          j;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    exp_tt = '0;
    fn_tt  = '0;
    sel    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk("rst_vec",  32'(vec_s),  32'd0);
    chk("rst_tt",   32'(tt_s),   32'd0);
    chk("rst_ones", 32'(ones_s), 32'd0);
    chk("rst_err",  32'(err_s),  32'd0);
    rst = 1'b0;

    // AND function, then XOR parity matched and mismatched.
    run_sweep(16'h8000, 16'h8000, 1'b0, 0);
    run_sweep(16'h6996, 16'h6996, 1'b0, 0);
    run_sweep(16'h6996, 16'h6990, 1'b0, 0);

    // Abort 9 cycles in with start held high.
    run_sweep(16'($urandom), 16'h0000, 1'b1, 8);

    // Asynchronous reset in the middle of a sweep.
    fn_tt = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy_s), 32'd0);
    chk("mrst_done", 32'(done_s), 32'd0);
    chk("mrst_vec",  32'(vec_s),  32'd0);
    chk("mrst_tt",   32'(tt_s),   32'd0);
    chk("mrst_ones", 32'(ones_s), 32'd0);
    chk("mrst_err",  32'(err_s),  32'd0);
    chk("mrst_fe",   32'(fe_s),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mrst_nodone", 32'(done0 | done1 | busy0 | busy1), 32'd0);
    end
    run_sweep(16'hA5C3, 16'hA5C3, 1'b0, 0);

    // SETTLE=1 instance, constant-1 function, start held high.
    sel = 1'b1;
    run_sweep(16'hFFFF, 16'hFFFF, 1'b1, 0);

    for (int it = 0; it < 16; it++) begin
      sel = 1'($urandom_range(0, 1));
      S   = sel ? 1 : 2;
      fn  = 16'($urandom);
      ex  = ($urandom_range(0, 1) == 1) ? fn : (fn ^ 16'(1 << $urandom_range(0, 15)));
      j   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16 * S + 1)) : 0;
      run_sweep(fn, ex, 1'($urandom_range(0, 1)), j);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
